// File: rtl/handshake_byte_packer_if.sv
// handshake_byte_packer_if: upstream beat and downstream packed-word handshake bundle
interface handshake_byte_packer_if #(
    parameter int WORD_WIDTH = 8,
    parameter int PACK_NUM   = 4
);
    logic                           up_valid;
    logic [WORD_WIDTH-1:0]          up_data;
    logic                           up_last;
    logic                           up_ready;
    logic                           down_valid;
    logic [WORD_WIDTH*PACK_NUM-1:0] down_data;
    logic [PACK_NUM-1:0]            down_keep;
    logic                           down_last;
    logic                           down_ready;
    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_keep, down_last
    );
    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_data, down_keep, down_last
    );
endinterface

// File: rtl/handshake_byte_packer.sv
// handshake_byte_packer: packs WORD_WIDTH beats into PACK_NUM-lane words, valid/ready on both sides
module handshake_byte_packer #(
    parameter int WORD_WIDTH = 8,
    parameter int PACK_NUM   = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    handshake_byte_packer_if.slave bus
);
    localparam int CW = $clog2(PACK_NUM);
    typedef logic [PACK_NUM-1:0][WORD_WIDTH-1:0] lanes_t;
    lanes_t              asm_q, asm_d, data_q, data_d, word;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PACK_NUM-1:0] keep_q, keep_d, keep_w;
    logic                valid_q, valid_d, last_q, last_d;
    logic                accept, complete;
    assign bus.up_ready   = rst_n && (!valid_q || bus.down_ready);
    assign accept         = bus.up_valid && bus.up_ready;
    assign complete       = accept && (bus.up_last || cnt_q == CW'(PACK_NUM - 1));
    assign bus.down_valid = valid_q;
    assign bus.down_data  = data_q;
    assign bus.down_keep  = keep_q;
    assign bus.down_last  = last_q;
    // lanes above cnt are still zero because the buffer is cleared on every completion
    always_comb begin
        word   = asm_q;
        keep_w = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            word[i]   = CW'(i) == cnt_q ? bus.up_data : asm_q[i];
            keep_w[i] = CW'(i) <= cnt_q;
        end
    end
    always_comb begin
        asm_d   = complete ? '0 : accept ? word : asm_q;
        cnt_d   = complete ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        valid_d = complete || (valid_q && !bus.down_ready);
        data_d  = complete ? word : data_q;
        keep_d  = complete ? keep_w : keep_q;
        last_d  = complete ? bus.up_last : last_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_handshake_byte_packer.sv
// tb_handshake_byte_packer: directed and random handshake stimulus against a packing scoreboard
module tb_handshake_byte_packer;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;
    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    bit    done;
    word_t q[$];
    logic [7:0] ml[4];
    int    mc;
    handshake_byte_packer_if #(.WORD_WIDTH(8), .PACK_NUM(4)) bus ();
    handshake_byte_packer #(.WORD_WIDTH(8), .PACK_NUM(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #10 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, {31'd0, bus.down_valid}, 32'd1);
        chk({tag, "_data"}, bus.down_data, d);
        chk({tag, "_keep"}, {28'd0, bus.down_keep}, {28'd0, k});
        chk({tag, "_last"}, {31'd0, bus.down_last}, {31'd0, l});
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.down_valid}, 32'd0);
        chk({tag, "_data"}, bus.down_data, 32'd0);
        chk({tag, "_keep"}, {28'd0, bus.down_keep}, 32'd0);
        chk({tag, "_last"}, {31'd0, bus.down_last}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.up_ready}, 32'd0);
    endtask
    // called at posedge+1; returns at posedge+1 just after the beat was taken
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        bus.up_last  = l;
        @(negedge clk);
        while (!bus.up_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, bus.up_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        bus.up_data  = 8'($urandom);
        bus.up_last  = 1'($urandom);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        word_t w;
        bit exp_ready;
        bus.up_valid = 1'b0;
        bus.up_data = '0;
        bus.up_last = 1'b0;
        bus.down_ready = 1'b0;
        ml = '{default: '0};
        mc = 0;
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                    ml = '{default: '0};
                    mc = 0;
                    chk_zero("mon_reset");
                end else begin
                    exp_ready = q.size() == 0 || bus.down_ready;
                    chk("mon_up_ready", {31'd0, bus.up_ready}, {31'd0, exp_ready});
                    chk("mon_down_valid", {31'd0, bus.down_valid}, {31'd0, q.size() != 0});
                    if (q.size() != 0) begin
                        chk("mon_data", bus.down_data, q[0].d);
                        chk("mon_keep", {28'd0, bus.down_keep}, {28'd0, q[0].k});
                        chk("mon_last", {31'd0, bus.down_last}, {31'd0, q[0].l});
                        if (bus.down_ready) void'(q.pop_front());
                    end
                    if (bus.up_valid && exp_ready) begin
                        ml[mc] = bus.up_data;
                        if (bus.up_last || mc == 3) begin
                            w.d = {ml[3], ml[2], ml[1], ml[0]};
                            w.k = 4'((1 << (mc + 1)) - 1);
                            w.l = bus.up_last;
                            q.push_back(w);
                            ml = '{default: '0};
                            mc = 0;
                        end else mc++;
                    end
                end
            end
        join_none
        #3;
        chk_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {31'd0, bus.up_ready}, 32'd1);
        chk("rel_valid", {31'd0, bus.down_valid}, 32'd0);
        bus.down_ready = 1'b1;
        tick();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        chk_word("full", 32'h44332211, 4'b1111, 1'b1);
        tick();
        chk("full_one_cycle", {31'd0, bus.down_valid}, 32'd0);
        send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        chk_word("short", 32'h0000A2A1, 4'b0011, 1'b1);
        send(8'hB1, 1'b1);
        chk_word("lane0", 32'h000000B1, 4'b0001, 1'b1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        bus.down_ready = 1'b0;
        #1;
        chk("stall_ready", {31'd0, bus.up_ready}, 32'd0);
        repeat (5) begin
            tick();
            chk_word("stall_hold", 32'h44332211, 4'b1111, 1'b1);
        end
        bus.down_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'd0, bus.up_ready}, 32'd1);
        tick();
        chk("unstall_consumed", {31'd0, bus.down_valid}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("stream_ready", {31'd0, bus.up_ready}, 32'd1);
            send(8'(i), 1'b0);
            if (i == 4) chk_word("stream_w0", 32'h04030201, 4'b1111, 1'b0);
            if (i == 8) chk_word("stream_w1", 32'h08070605, 4'b1111, 1'b0);
        end
        done = 1'b0;
        fork
            while (!done) begin
                tick();
                bus.down_ready = ~bus.down_ready;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(8'($urandom), $urandom_range(0, 3) == 0);
                end
                done = 1'b1;
            end
        join
        bus.down_ready = 1'b1;
        send(8'hEE, 1'b1);
        repeat (3) tick();
        chk("drain_empty", q.size(), 32'd0);
        bus.down_ready = 1'b0;
        send(8'h99, 1'b1);
        tick();
        chk_word("pre_reset_stall", 32'h00000099, 4'b0001, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        chk_zero("async_stall");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel2_ready", {31'd0, bus.up_ready}, 32'd1);
        chk("rel2_valid", {31'd0, bus.down_valid}, 32'd0);
        bus.down_ready = 1'b1;
        send(8'h61, 1'b0); send(8'h62, 1'b0);
        #4;
        rst_n = 1'b0;
        #1;
        chk_zero("async_midword");
        tick();
        rst_n = 1'b1;
        send(8'h55, 1'b1);
        chk_word("post_reset", 32'h00000055, 4'b0001, 1'b1);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/handshake_byte_packer.md
HANDSHAKE_BYTE_PACKER -- requirements
Module: handshake_byte_packer

Interface
REQ-001 SHALL provide parameter WORD_WIDTH, default 8: width of one upstream beat (lane).
REQ-002 SHALL provide parameter PACK_NUM, default 4: lanes per output word; legal range 2..16.
REQ-003 SHALL provide port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL provide port up_valid  input  1: upstream beat valid.
REQ-006 SHALL provide port up_data  input  WORD_WIDTH: upstream beat payload.
REQ-007 SHALL provide port up_last  input  1: the beat is the final beat of a packet; it closes the current word.
REQ-008 SHALL provide port up_ready  output  1: packer accepts a beat this cycle.
REQ-009 SHALL provide port down_valid  output  1: packed word valid.
REQ-010 SHALL provide port down_data  output  WORD_WIDTH*PACK_NUM: packed word; lane 0 = bits [WORD_WIDTH-1:0].
REQ-011 SHALL provide port down_keep  output  PACK_NUM: per-lane valid mask.
REQ-012 SHALL provide port down_last  output  1: word contains the packet's final beat.
REQ-013 SHALL provide port down_ready  input  1: downstream accepts the word.

Function
REQ-014 SHALL treat a beat as accepted when up_valid && up_ready at a rising clk edge, and treat a word as consumed when down_valid && down_ready.
REQ-015 SHALL drive up_ready = rst_n && (!down_valid || down_ready), combinationally.
REQ-016 SHALL keep an assembly buffer and a lane counter cnt (0..PACK_NUM-1); an accepted beat is written to lane cnt.
REQ-017 SHALL complete a word on the beat accepted with cnt == PACK_NUM-1 or with up_last = 1.
REQ-018 On a non-completing accept, SHALL increment cnt and leave the down_* outputs unchanged.
REQ-019 On a completing accept, SHALL load the output register at that edge: down_data = buffer lanes 0..cnt-1 plus the current beat in lane cnt, lanes above cnt = 0; down_keep = ones in bits 0..cnt; down_last = up_last; down_valid = 1.
REQ-020 On a completing accept, SHALL clear cnt and the assembly buffer at the same edge.
REQ-021 SHALL present a completed word on down_* the cycle after its completing beat is accepted (latency 1).
REQ-022 SHALL sustain 1 beat per cycle when down_ready is held 1.
REQ-023 SHALL hold down_data, down_keep and down_last stable while down_valid && !down_ready.
REQ-024 SHALL clear down_valid on consumption when no completing accept occurs at the same edge.
REQ-025 When a consumption and a completing accept occur at the same edge, SHALL load the new word with down_valid staying 1, with no bubble and no loss.
REQ-026 SHALL ignore up_data and up_last when no accept occurs.
REQ-027 SHALL not let down_valid depend combinationally on down_ready.
REQ-028 SHALL not let up_ready depend on up_valid, up_data or up_last.
REQ-029 SHALL accept up_last with cnt == PACK_NUM-1 as a single full word with down_last = 1 and down_keep all ones.
REQ-030 SHALL accept up_last with cnt == 0 as a one-lane word with down_keep = 1.

Reset
REQ-031 While rst_n = 0, SHALL force down_valid = 0, down_data = 0, down_keep = 0, down_last = 0, cnt = 0, assembly buffer = 0 and up_ready = 0.
REQ-032 SHALL take effect immediately on rst_n falling, regardless of clk, including mid-word or mid-stall, and SHALL discard any partial word.
REQ-033 SHALL drive up_ready = 1 at the first rising edge after rst_n rises, with down_valid = 0.

Verification
REQ-034 Bench SHALL cover: down_ready = 1; beats 0x11, 0x22, 0x33, 0x44 with up_last on 0x44 -> one cycle later down_data = 0x44332211, down_keep = 4'b1111, down_last = 1, one cycle valid.
REQ-035 Bench SHALL cover: beats 0xA1, 0xA2 with up_last on 0xA2 -> down_data = 0x0000A2A1, down_keep = 4'b0011, down_last = 1; the next beat lands in lane 0.
REQ-036 Bench SHALL cover: down_ready = 0 after word 0x44332211 is valid -> up_ready = 0; down_* held for 5 cycles; down_ready = 1 -> word consumed, up_ready = 1 the same cycle.
REQ-037 Bench SHALL cover: continuous 8 beats 0x01..0x08, no up_last, down_ready = 1 -> words 0x04030201 then 0x08070605 on consecutive word slots, keep = 4'b1111, last = 0, up_ready never low.
REQ-038 Bench SHALL cover: down_ready toggling 1/0 every cycle (clk period 20 ns) with a random upstream -> no beat lost or duplicated, in-order lanes, held data stable during stalls.
REQ-039 Bench SHALL cover: rst_n pulled low after 2 beats of a word, asynchronously mid-cycle -> all outputs 0 immediately; after release, beat 0x55 with up_last -> down_data = 0x00000055, down_keep = 4'b0001.
